// File: rtl/awgn_pkg.sv
// Shared constants for the sqrt coefficient path: default table geometry,
// coefficient-word field positions and the response-register state type.
package awgn_pkg;

  localparam int SQRT_ADDR_W = 6;
  localparam int SQRT_C1_W   = 12;
  localparam int SQRT_C0_W   = 20;

  // Coefficient word layout: {c1 slope, c0 offset}
  localparam int SQRT_C1_LSB = 20;
  localparam int SQRT_C0_LSB = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sqrt_arb2.sv
// Two-way grant for the sqrt coefficient table.
// SQRT_COEFF_ARB_RR_EN selects round-robin (grant the requester not granted
// last time); without it requester 0 always wins.
module sqrt_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

`ifdef SQRT_COEFF_ARB_RR_EN
  // Round-robin: on contention favour the requester that did not win last
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  // Fixed priority: requester 0 beats requester 1
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/sqrt_coeff_arbiter.sv
// Arbitrates two requesters onto one external combinational sqrt coefficient
// table and returns the split {c1, c0} word through a single response
// register (1-cycle latency, one response per cycle when drained).
// Build option: SQRT_COEFF_ARB_RR_EN enables round-robin arbitration;
// default is fixed priority with requester 0 winning.
module sqrt_coeff_arbiter
  import awgn_pkg::*;
#(
  parameter int ADDR_W = SQRT_ADDR_W,
  parameter int C1_W   = SQRT_C1_W,
  parameter int C0_W   = SQRT_C0_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  input  logic [ADDR_W-1:0]    req_addr0,
  input  logic [ADDR_W-1:0]    req_addr1,
  output logic [1:0]           req_ready,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [C1_W+C0_W-1:0] rom_data,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [C1_W-1:0]      resp_c1,
  output logic [C0_W-1:0]      resp_c0
);

  arb_state_e      st;
  logic            owner;
  logic            last;
  logic            drain;
  logic            can_grant;
  logic [1:0]      gnt;
  logic [C1_W-1:0] c1_q;
  logic [C0_W-1:0] c0_q;

  // Register is free when empty, or when its owner takes the response now.
  // Non-owner resp_ready bits are ignored by construction.
  assign drain     = (st == ST_FULL) && resp_ready[owner];
  assign can_grant = rst_n && ((st == ST_EMPTY) || drain);

  sqrt_arb2 u_arb (
    .req  (req_valid),
    .last (last),
    .en   (can_grant),
    .gnt  (gnt)
  );

  assign req_ready = gnt;

  // Table address follows the winner; requester 0's address when idle
  assign rom_addr = gnt[1] ? req_addr1 : req_addr0;

  // Response register: capture on accept, clear on handshake, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= ST_EMPTY;
      owner <= 1'b0;
      c1_q  <= '0;
      c0_q  <= '0;
    end else if (|gnt) begin
      st    <= ST_FULL;
      owner <= gnt[1];
      c1_q  <= rom_data[SQRT_C1_LSB +: C1_W];
      c0_q  <= rom_data[SQRT_C0_LSB +: C0_W];
    end else if (drain) begin
      st    <= ST_EMPTY;
    end
  end

`ifdef SQRT_COEFF_ARB_RR_EN
  // Last-granted pointer moves only on an accepted request; reset value 1
  // makes requester 0 the first winner on contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end
`else
  assign last = 1'b1;
`endif

  assign resp_valid = (st == ST_FULL) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign resp_c1    = c1_q;
  assign resp_c0    = c0_q;

endmodule

// File: tb/tb_sqrt_coeff_arbiter.sv
// Directed bench for sqrt_coeff_arbiter: a vector table for single-cycle
// behaviour plus hand sequences for contention, stall and mid-run reset.
// Expectations for contention follow SQRT_COEFF_ARB_RR_EN if defined.
module tb_sqrt_coeff_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [5:0]  req_addr0, req_addr1;
  logic [1:0]  req_ready;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [11:0] resp_c1;
  logic [19:0] resp_c0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sqrt_coeff_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_ready  (req_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_c1    (resp_c1),
    .resp_c0    (resp_c0)
  );

  // External coefficient table model
  always_comb begin
    case (rom_addr)
      6'd0:    rom_data = {12'h168, 20'h2D6E2};
      6'd5:    rom_data = {12'h155, 20'h11111};
      6'd10:   rom_data = {12'h1AA, 20'h22222};
      6'd63:   rom_data = {12'h100, 20'h3FDFD};
      default: rom_data = {12'hABC, 20'h0BEEF};
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  rv;
    logic [5:0]  a0;
    logic [5:0]  a1;
    logic [1:0]  rr;
    logic [1:0]  exp_ready;
    logic [5:0]  exp_addr;
    logic [1:0]  exp_rvalid;
    logic [11:0] exp_c1;
    logic [19:0] exp_c0;
  } vec_t;

  vec_t vecs[10];

  // Drive at negedge, check combinational grant, then registered response
  task automatic step(input logic [1:0] rv, input logic [5:0] a0, input logic [5:0] a1,
                      input logic [1:0] rr);
    @(negedge clk);
    req_valid = rv; req_addr0 = a0; req_addr1 = a1; resp_ready = rr;
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic [1:0] ev, input logic [11:0] c1,
                          input logic [19:0] c0);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'(ev));
    if (ev != 2'b00) begin
      chk({tag, " resp_c1"}, 32'(resp_c1), 32'(c1));
      chk({tag, " resp_c0"}, 32'(resp_c0), 32'(c0));
    end
  endtask

  logic [1:0]  exp_g[4];
  logic [11:0] hold_c1;
  logic [19:0] hold_c0;
  logic [1:0]  hold_v;

  initial begin
    // {rv, a0, a1, rr, ready, rom_addr, resp_valid, c1, c0}
    vecs[0] = '{2'b01, 6'd0,  6'd0,  2'b00, 2'b01, 6'd0,  2'b01, 12'h168, 20'h2D6E2};
    vecs[1] = '{2'b00, 6'd0,  6'd0,  2'b00, 2'b00, 6'd0,  2'b01, 12'h168, 20'h2D6E2};
    vecs[2] = '{2'b10, 6'd0,  6'd63, 2'b10, 2'b00, 6'd0,  2'b01, 12'h168, 20'h2D6E2};
    vecs[3] = '{2'b00, 6'd0,  6'd0,  2'b01, 2'b00, 6'd0,  2'b00, 12'h000, 20'h00000};
    vecs[4] = '{2'b10, 6'd0,  6'd63, 2'b10, 2'b10, 6'd63, 2'b10, 12'h100, 20'h3FDFD};
    vecs[5] = '{2'b00, 6'd0,  6'd0,  2'b10, 2'b00, 6'd0,  2'b00, 12'h000, 20'h00000};
    vecs[6] = '{2'b01, 6'd5,  6'd0,  2'b00, 2'b01, 6'd5,  2'b01, 12'h155, 20'h11111};
    vecs[7] = '{2'b01, 6'd10, 6'd0,  2'b01, 2'b01, 6'd10, 2'b01, 12'h1AA, 20'h22222};
    vecs[8] = '{2'b10, 6'd0,  6'd63, 2'b01, 2'b10, 6'd63, 2'b10, 12'h100, 20'h3FDFD};
    vecs[9] = '{2'b00, 6'd0,  6'd0,  2'b10, 2'b00, 6'd0,  2'b00, 12'h000, 20'h00000};

    rst_n = 1'b0; req_valid = 2'b11; req_addr0 = '0; req_addr1 = '0; resp_ready = '0;
    #2;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_c1", 32'(resp_c1), 32'd0);
    chk("reset resp_c0", 32'(resp_c0), 32'd0);
    @(negedge clk); @(negedge clk);
    chk("reset hold resp_valid", 32'(resp_valid), 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rv, vecs[i].a0, vecs[i].a1, vecs[i].rr);
      chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
      @(posedge clk); #1;
      chk_resp($sformatf("vec%0d", i), vecs[i].exp_rvalid, vecs[i].exp_c1, vecs[i].exp_c0);
    end

    // Contention, both draining every cycle. After vec8 requester 1 won
    // last, so round-robin starts with requester 0.
`ifdef SQRT_COEFF_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 6'd5, 6'd10, 2'b11);
      chk($sformatf("contend%0d req_ready", i), 32'(req_ready), 32'(exp_g[i]));
      @(posedge clk); #1;
      if (exp_g[i] == 2'b01) chk_resp($sformatf("contend%0d", i), 2'b01, 12'h155, 20'h11111);
      else                   chk_resp($sformatf("contend%0d", i), 2'b10, 12'h1AA, 20'h22222);
    end
    hold_v  = exp_g[3];
    hold_c1 = (exp_g[3] == 2'b01) ? 12'h155 : 12'h1AA;
    hold_c0 = (exp_g[3] == 2'b01) ? 20'h11111 : 20'h22222;

    // Stall: FULL, nobody draining, both requesting
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 6'd0, 6'd63, 2'b00);
      chk($sformatf("stall%0d req_ready", i), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk_resp($sformatf("stall%0d", i), hold_v, hold_c1, hold_c0);
    end

    // Reset while FULL: outputs clear immediately, no grants while low
    @(negedge clk);
    req_valid = 2'b11; req_addr0 = 6'd5; req_addr1 = 6'd10; resp_ready = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("midrst resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst resp_c1", 32'(resp_c1), 32'd0);
    chk("midrst resp_c0", 32'(resp_c0), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    chk("postrst no reissue", 32'(resp_valid), 32'd0);
    step(2'b11, 6'd5, 6'd10, 2'b00);
    chk("postrst first grant", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    chk_resp("postrst", 2'b01, 12'h155, 20'h11111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sqrt_coeff_arbiter.md
SQRT_COEFF_ARBITER -- requirements
Module: sqrt_coeff_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning sqrt coefficient table address width.
REQ-002 SHALL have parameter C1_W, default 12, meaning slope coefficient width (table word bits [31:20]).
REQ-003 SHALL have parameter C0_W, default 20, meaning offset coefficient width (table word bits [19:0]).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  in  2  per-requester lookup request, bit i = requester i.
REQ-007 SHALL have port req_addr0  in  ADDR_W  requester 0 table address.
REQ-008 SHALL have port req_addr1  in  ADDR_W  requester 1 table address.
REQ-009 SHALL have port req_ready  out  2  one-hot-or-zero grant; request i accepted when req_valid[i] & req_ready[i].
REQ-010 SHALL have port rom_addr  out  ADDR_W  address driven to shared combinational coefficient table.
REQ-011 SHALL have port rom_data  in  C1_W+C0_W  coefficient word returned combinationally by the table.
REQ-012 SHALL have port resp_valid  out  2  one-hot-or-zero response valid, bit = owning requester.
REQ-013 SHALL have port resp_ready  in  2  per-requester response acceptance.
REQ-014 SHALL have port resp_c1  out  C1_W  registered slope coefficient, qualified by resp_valid.
REQ-015 SHALL have port resp_c0  out  C0_W  registered offset coefficient, qualified by resp_valid.

Function
REQ-016 SHALL hold one response register (valid flag, owner id, c1, c0); state EMPTY when flag clear, FULL when set.
REQ-017 SHALL raise at most one req_ready bit, and only when EMPTY, or FULL with resp_ready[owner] high the same cycle.
REQ-018 SHALL drive rom_addr combinationally from req_addr of the granted requester; req_addr0 when no grant.
REQ-019 SHALL, on acceptance, capture rom_data[31:20] into resp_c1 and rom_data[19:0] into resp_c0, set owner, go FULL: latency exactly 1 cycle.
REQ-020 SHALL keep resp_c1, resp_c0, resp_valid stable while FULL and resp_ready[owner] low.
REQ-021 SHALL go EMPTY after response handshake with no new acceptance in that cycle; back-to-back acceptance yields one response per cycle.
REQ-022 SHALL ignore resp_ready bits of non-owning requesters.
REQ-023 SHALL, with both requests valid and grant possible, grant the requester not most recently granted; single valid requester granted directly.
REQ-024 SHALL update the last-granted pointer only on an accepted request.

Reset
REQ-025 SHALL on rst_n low immediately force resp_valid=0, resp_c1=0, resp_c0=0, owner=0, last-granted=1, state EMPTY.
REQ-026 SHALL drop any pending response when reset asserts mid-operation; no response reissued after release.
REQ-027 SHALL grant no request while rst_n is low.

Configuration
REQ-028 SHALL compile round-robin arbitration (REQ-023, REQ-024) when macro SQRT_COEFF_ARB_RR_EN is defined.
REQ-029 SHALL, without SQRT_COEFF_ARB_RR_EN, use fixed priority with requester 0 always winning; pointer logic absent.

Structure
REQ-030 SHALL take ADDR_W, C1_W, C0_W defaults and coefficient-word field positions from shared package awgn_pkg.
REQ-031 SHALL contain one sub-module, sqrt_arb2, computing the 2-way grant from requests, pointer and enable.
REQ-032 SHALL not instantiate the coefficient table; the table connects externally via rom_addr/rom_data.

Verification
REQ-033 SHALL test: after reset, req_valid=01, req_addr0=0 -> req_ready=01, next cycle resp_valid=01, resp_c1=0x168, resp_c0=0x2D6E2.
REQ-034 SHALL test: req_valid=10, req_addr1=63, resp_ready=10 -> next cycle resp_valid=10, resp_c1=0x100, resp_c0=0x3FDFD, drained following cycle.
REQ-035 SHALL test: req_valid=11 held 4 cycles, resp_ready=11 (RR build) -> grants 01,10,01,10, one response per cycle.
REQ-036 SHALL test: FULL with resp_ready=00 for 3 cycles, req_valid=11 -> req_ready=00, resp outputs unchanged.
REQ-037 SHALL test: rst_n low one cycle while FULL -> resp_valid=0 and outputs zero immediately; first grant after release goes to requester 0.
REQ-038 SHALL test: build without macro, req_valid=11 for 3 cycles, resp_ready=11 -> grants 01,01,01.
